// File: rtl/if_fetch.sv
// Instruction fetch stage: launches one memory request at a time and buffers
// returned {pc, instr} pairs in a 2-entry in-order queue for decode.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_adv,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              id_ready,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_count
);

    // Handshakes: imem request transfers when imem_req && imem_ready; decode
    // transfer when o_valid && id_ready; imem_rvalid answers the oldest request.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [1:0]        count;
    logic [ADDR_W-1:0] head_pc, tail_pc;
    logic [DATA_W-1:0] head_instr, tail_instr;

    logic pop, push, launch;

    assign o_valid   = (count != 2'd0);
    assign o_pc      = head_pc;
    assign o_instr   = head_instr;
    assign dbg_state = state;
    assign dbg_count = count;

    assign pop    = o_valid && id_ready;
    assign push   = (state == WAIT) && imem_rvalid && !redirect;
    // A slot is free if the queue is not full, or a pop frees one this cycle.
    assign launch = (state == IDLE) && !redirect && ((count != 2'd2) || pop);
    assign pc_adv = (state == REQ) && imem_ready && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        imem_req <= 1'b0;
                        state    <= imem_ready ? DROP : IDLE;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) state <= IDLE;
                    else if (redirect) state <= DROP;
                end
                DROP: begin
                    // The stale response closes DROP even if another redirect arrives with it.
                    if (imem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= 2'd0;
            head_pc    <= '0;
            head_instr <= '0;
            tail_pc    <= '0;
            tail_instr <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= imem_addr;
                        head_instr <= imem_rdata;
                    end else begin
                        tail_pc    <= imem_addr;
                        tail_instr <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc    <= imem_addr;
                        head_instr <= imem_rdata;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= imem_addr;
                        tail_instr <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
